// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: buffers rx_dv-delimited frames, releases only whole good frames on valid/ready.
// Optional CHECKSUM_EN appends an XOR checksum entry after each frame's data bytes.
module rx_frame_buffer #(
  parameter int DEPTH   = 64,
  parameter int MAX_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        drop_pulse,
  output logic [15:0] frame_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MAX_LEN + 1);
`ifdef CHECKSUM_EN
  typedef enum logic [1:0] {SYNC, IDLE, RECV, CKSUM} state_t;
`else
  typedef enum logic [1:0] {SYNC, IDLE, RECV} state_t;
`endif
  state_t state_q, state_d;
  logic [8:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
  logic [7:0] hold_q, hold_d, cs_q, cs_d;
  logic [LW-1:0] len_q, len_d;
  logic bad_q, bad_d, drop_q, drop_d;
  logic [15:0] cnt_q, cnt_d;
  logic we, full, rd_en;
  logic [8:0] wdata;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // Only committed entries are visible, so a frame in progress never leaks out.
  assign out_valid = rd_q != cm_q;
  assign {out_last, out_data} = out_valid ? mem_q[rd_q[AW-1:0]] : 9'd0;
  assign rd_en = out_valid && out_ready;
  assign drop_pulse = drop_q;
  assign frame_cnt = cnt_q;
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    cm_d = cm_q;
    rd_d = rd_en ? rd_q + 1'b1 : rd_q;
    hold_d = hold_q;
    cs_d = cs_q;
    len_d = len_q;
    bad_d = bad_q;
    drop_d = 1'b0;
    cnt_d = cnt_q;
    we = 1'b0;
    wdata = {1'b0, hold_q};
    case (state_q)
      SYNC: state_d = rx_dv ? SYNC : IDLE;
      IDLE: if (rx_dv) begin
        state_d = RECV;
        hold_d = rxd;
        cs_d = rxd;
        len_d = LW'(1);
        bad_d = 1'b0;
      end
      RECV: if (rx_dv) begin
        hold_d = rxd;
        cs_d = cs_q ^ rxd;
        if (!bad_q) begin
          if (len_q == LW'(MAX_LEN) || full) bad_d = 1'b1;
          else begin
            we = 1'b1;
            len_d = len_q + 1'b1;
          end
        end
      end else begin
        state_d = IDLE;
        if (bad_q || full) begin
          wr_d = cm_q;
          drop_d = 1'b1;
        end else begin
          we = 1'b1;
`ifdef CHECKSUM_EN
          state_d = CKSUM;
`else
          wdata = {1'b1, hold_q};
          cm_d = wr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
`ifdef CHECKSUM_EN
      CKSUM: begin
        state_d = rx_dv ? RECV : IDLE;
        if (full) begin
          wr_d = cm_q;
          drop_d = 1'b1;
        end else begin
          we = 1'b1;
          wdata = {1'b1, cs_q};
          cm_d = wr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
        if (rx_dv) begin
          hold_d = rxd;
          cs_d = rxd;
          len_d = LW'(1);
          bad_d = 1'b0;
        end
      end
`endif
      default: state_d = SYNC;
    endcase
    wr_d = we ? wr_q + 1'b1 : wr_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      wr_q <= '0;
      cm_q <= '0;
      rd_q <= '0;
      hold_q <= '0;
      cs_q <= '0;
      len_q <= '0;
      bad_q <= 1'b0;
      drop_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      cm_q <= cm_d;
      rd_q <= rd_d;
      hold_q <= hold_d;
      cs_q <= cs_d;
      len_q <= len_d;
      bad_q <= bad_d;
      drop_q <= drop_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule
